// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared state enum and binary-to-Gray helper for the Gray sequence generator
package gray_pkg;

  localparam int GRAY_MAX_W = 64;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } gray_seq_state_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_bin2gray.sv
// rtl/gray_bin2gray.sv - combinational binary-to-Gray conversion of one WIDTH-bit word
module gray_bin2gray
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  // Zero-extension keeps the top Gray bit equal to the top binary bit.
  assign o_gray = WIDTH'(bin2gray(GRAY_MAX_W'(i_bin)));

endmodule

// File: rtl/gray_seq_gen.sv
// rtl/gray_seq_gen.sv - up/down binary counter streaming registered Gray words with valid/ready handshake
module gray_seq_gen
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  gray_seq_state_e  r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  gray_seq_state_e  w_state_next;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  logic [WIDTH-1:0] w_step;
  logic             w_step_wraps;
  logic [WIDTH-1:0] w_bin_sel;
  logic [WIDTH-1:0] w_gray_conv;

  assign w_step       = dir ? (r_cnt - ONE) : (r_cnt + ONE);
  assign w_step_wraps = dir ? (r_cnt == '0) : (r_cnt == '1);

  // IDLE presents the current count; ACTIVE presents the count after this transfer's step.
  assign w_bin_sel = (r_state == ST_IDLE) ? r_cnt : w_step;

  gray_bin2gray #(
    .WIDTH(WIDTH)
  ) u_bin2gray (
    .i_bin (w_bin_sel),
    .o_gray(w_gray_conv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_gray_next  = r_gray;
    w_wrap_next  = r_wrap;
    if (load) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = load_val;
      w_wrap_next  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            w_state_next = ST_ACTIVE;
            w_gray_next  = w_gray_conv;
            w_wrap_next  = 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (out_ready) begin
            w_cnt_next = w_step;
            if (en) begin
              w_gray_next = w_gray_conv;
              w_wrap_next = w_step_wraps;
            end else begin
              w_state_next = ST_IDLE;
              w_wrap_next  = 1'b0;
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign out_valid = (r_state == ST_ACTIVE);
  assign gray      = r_gray;
  assign wrap      = r_wrap;

endmodule
